// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//
// Shared definitions for the cache-to-memory arbiter and its helpers:
//   - default byte-address and cache-line widths
//   - line offset width (8-byte lines, so the low 3 address bits are zero)
//   - arbiter FSM state encoding
//   - requester side identifier (I-cache or D-cache)
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int LINE_W_DEF    = 64;
    localparam int LINE_OFFSET_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_FILL = 3'd1,
        D_WB   = 3'd2,
        D_FILL = 3'd3,
        RESP   = 3'd4
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

endpackage : cache_pkg

// File: rtl/mem_arb_rr.sv
// ---------------------------------------------------------------------------
// mem_arb_rr
//
// Two-requester round-robin tie breaker for the memory arbiter.
// When only one side requests, that side wins. When both request, the side
// that was NOT granted last wins. The last-grant flop resets to SIDE_I so the
// very first tie after reset goes to the D-cache.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   i_req  in   I-cache side is requesting
//   d_req  in   D-cache side is requesting
//   take   in   the arbiter is accepting the current grant this cycle
//   grant  out  winning side for this cycle (only meaningful with a request)
// ---------------------------------------------------------------------------
module mem_arb_rr
    import cache_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_req,
    input  logic      d_req,
    input  logic      take,
    output arb_side_t grant
);

    arb_side_t last_grant;

    always_comb begin
        grant = SIDE_I;
        if (i_req && d_req) begin
            // Alternate on contention so neither cache can starve the other.
            grant = (last_grant == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (d_req) begin
            grant = SIDE_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= SIDE_I;
        end else if (take && (i_req || d_req)) begin
            last_grant <= grant;
        end
    end

endmodule : mem_arb_rr

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates a single line-wide memory port between an I-cache miss fill and
// a D-cache miss (optionally preceded by a dirty-victim writeback). One
// transaction is in flight at a time; at grant the request side, the fill
// address, the victim address and the victim line are captured, so the
// requesting cache may change its inputs freely until the rdy pulse.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset; aborts any transaction
//   i_req      in   I-cache fill request (level, held until i_rdy)
//   i_addr     in   I-cache miss address
//   i_rdy      out  one-cycle pulse, i_line valid
//   i_line     out  last line filled for the I-cache
//   d_req      in   D-cache request (level, held until d_rdy)
//   d_wb       in   victim is dirty, write it back before the fill
//   d_addr     in   D-cache miss (fill) address
//   d_wb_addr  in   dirty victim address
//   d_wb_line  in   dirty victim data
//   d_rdy      out  one-cycle pulse, d_line valid
//   d_line     out  last line filled for the D-cache
//   mem_en     out  memory access request, held until mem_valid
//   mem_we     out  1 = write, 0 = read
//   mem_addr   out  line-aligned memory address
//   mem_wdata  out  write data (victim line)
//   mem_rdata  in   read data, valid with mem_valid
//   mem_valid  in   one-cycle pulse, memory access done
// ---------------------------------------------------------------------------
module mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [LINE_W-1:0] i_line,

    input  logic              d_req,
    input  logic              d_wb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wb_addr,
    input  logic [LINE_W-1:0] d_wb_line,
    output logic              d_rdy,
    output logic [LINE_W-1:0] d_line,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    arb_state_t        state;
    arb_state_t        state_next;
    arb_side_t         side;
    arb_side_t         grant;
    logic              take;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_line;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    endfunction

    mem_arb_rr u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (i_req),
        .d_req (d_req),
        .take  (take),
        .grant (grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction context, captured once at grant and held until the next
    // grant. Only the fill address of the winning side is kept; the victim
    // fields are captured unconditionally since they are only consumed when
    // the D side was granted with d_wb set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            side      <= SIDE_I;
            fill_addr <= '0;
            wb_addr   <= '0;
            wb_line   <= '0;
        end else if (take) begin
            side      <= grant;
            fill_addr <= (grant == SIDE_D) ? d_addr : i_addr;
            wb_addr   <= d_wb_addr;
            wb_line   <= d_wb_line;
        end
    end

    // Fill data registers. Only a read completion updates them, so a stray
    // mem_valid in IDLE/RESP, or the write completion in D_WB, leaves the
    // previously returned line untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_line <= '0;
            d_line <= '0;
        end else if (mem_valid) begin
            if (state == I_FILL) begin
                i_line <= mem_rdata;
            end
            if (state == D_FILL) begin
                d_line <= mem_rdata;
            end
        end
    end

    assign mem_wdata = wb_line;

    // Next state and Moore outputs.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = line_align(fill_addr);
        i_rdy      = 1'b0;
        d_rdy      = 1'b0;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    take = 1'b1;
                    if (grant == SIDE_D) begin
                        state_next = d_wb ? D_WB : D_FILL;
                    end else begin
                        state_next = I_FILL;
                    end
                end
            end

            I_FILL, D_FILL: begin
                mem_en = 1'b1;
                if (mem_valid) begin
                    state_next = RESP;
                end
            end

            D_WB: begin
                // The fill follows directly, so mem_en stays high across the
                // boundary and only mem_we/mem_addr change.
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = line_align(wb_addr);
                if (mem_valid) begin
                    state_next = D_FILL;
                end
            end

            RESP: begin
                // Always return to IDLE; a new grant is only taken from IDLE
                // so the requester has a cycle to drop its request.
                i_rdy      = (side == SIDE_I);
                d_rdy      = (side == SIDE_D);
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Cycle-stepped bench for mem_arbiter. A transaction-level reference model
// predicts, from the request rules, which side is served, the ordered list of
// memory accesses each grant must produce, and which rdy pulse/line follows.
// A behavioural memory with variable latency answers the DUT's accesses.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_rdy;
    logic [LW-1:0] i_line;
    logic          d_req;
    logic          d_wb;
    logic [AW-1:0] d_addr;
    logic [AW-1:0] d_wb_addr;
    logic [LW-1:0] d_wb_line;
    logic          d_rdy;
    logic [LW-1:0] d_line;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_valid;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdy     (i_rdy),
        .i_line    (i_line),
        .d_req     (d_req),
        .d_wb      (d_wb),
        .d_addr    (d_addr),
        .d_wb_addr (d_wb_addr),
        .d_wb_line (d_wb_line),
        .d_rdy     (d_rdy),
        .d_line    (d_line),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } acc_t;

    acc_t          exp_q[$];
    int            m_phase   = 0;   // 0: no transaction, 1: accesses pending, 2: response cycle
    bit            m_side_d  = 1'b0;
    bit            m_last_d  = 1'b0;
    logic [LW-1:0] exp_i_line = '0;
    logic [LW-1:0] exp_d_line = '0;

    // Inputs as applied during the cycle that ends at the next edge.
    logic          p_rst_n, p_i_req, p_d_req, p_d_wb, p_mem_valid;
    logic [AW-1:0] p_i_addr, p_d_addr, p_d_wb_addr;
    logic [LW-1:0] p_d_wb_line, p_mem_rdata;

    // ---------------- behavioural memory ----------------
    logic [LW-1:0] mem_arr [logic [AW-1:0]];
    int            acc_cnt     = 0;
    int            acc_lat     = 0;
    int            fixed_lat   = -1;
    bit            spurious_en = 1'b0;
    bit            force_en    = 1'b0;
    logic [LW-1:0] force_rdata = '0;
    bit            auto_req    = 1'b0;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~(AW'(7));
    endfunction

    function automatic logic [LW-1:0] mem_read(input logic [AW-1:0] a);
        if (!mem_arr.exists(a)) begin
            mem_arr[a] = {$urandom, $urandom};
        end
        return mem_arr[a];
    endfunction

    task automatic model_update();
        if (!p_rst_n) begin
            m_phase    = 0;
            m_last_d   = 1'b0;
            exp_i_line = '0;
            exp_d_line = '0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (p_i_req || p_d_req) begin
                        // Lone requester wins; on a tie the side not served last wins.
                        m_side_d = p_d_req && !(p_i_req && m_last_d);
                        m_last_d = m_side_d;
                        if (m_side_d) begin
                            if (p_d_wb) exp_q.push_back('{1'b1, align(p_d_wb_addr), p_d_wb_line});
                            exp_q.push_back('{1'b0, align(p_d_addr), '0});
                        end else begin
                            exp_q.push_back('{1'b0, align(p_i_addr), '0});
                        end
                        m_phase = 1;
                    end
                end
                1: begin
                    if (p_mem_valid) begin
                        if (!exp_q[0].we) begin
                            if (m_side_d) exp_d_line = p_mem_rdata;
                            else          exp_i_line = p_mem_rdata;
                        end
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic model_check();
        if (m_phase == 1) begin
            check_eq("mem_en_busy", 64'(mem_en), 64'(1));
            check_eq("mem_we", 64'(mem_we), 64'(exp_q[0].we));
            check_eq("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
            if (exp_q[0].we) check_eq("mem_wdata", mem_wdata, exp_q[0].data);
            check_eq("rdy_busy", 64'({i_rdy, d_rdy}), 64'(0));
        end else if (m_phase == 2) begin
            check_eq("mem_ctl_resp", 64'({mem_en, mem_we}), 64'(0));
            check_eq("rdy_resp", 64'({i_rdy, d_rdy}), 64'({!m_side_d, m_side_d}));
        end else begin
            check_eq("mem_ctl_idle", 64'({mem_en, mem_we}), 64'(0));
            check_eq("rdy_idle", 64'({i_rdy, d_rdy}), 64'(0));
        end
        check_eq("i_line", i_line, exp_i_line);
        check_eq("d_line", d_line, exp_d_line);
    endtask

    task automatic mem_respond();
        if (mem_en) begin
            if (mem_valid) acc_cnt = 0;   // previous access finished, a new one starts now
            acc_cnt++;
            if (acc_cnt == 1) acc_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
            if (acc_cnt == acc_lat + 1) begin
                mem_valid = 1'b1;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    mem_rdata = {$urandom, $urandom};
                end else begin
                    mem_rdata = force_en ? force_rdata : mem_read(mem_addr);
                end
            end else begin
                mem_valid = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
        end else begin
            acc_cnt   = 0;
            mem_valid = spurious_en && ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom};
        end
    endtask

    task automatic drive_random();
        if (i_req) begin
            if (i_rdy) i_req = 1'b0;
            else if (m_phase == 1 && !m_side_d) i_addr = AW'($urandom);
        end else if ($urandom_range(0, 3) == 0) begin
            i_req  = 1'b1;
            i_addr = AW'($urandom);
        end
        if (d_req) begin
            if (d_rdy) d_req = 1'b0;
            else if (m_phase == 1 && m_side_d) begin
                d_wb      = 1'($urandom);
                d_addr    = AW'($urandom);
                d_wb_addr = AW'($urandom);
                d_wb_line = {$urandom, $urandom};
            end
        end else if ($urandom_range(0, 3) == 0) begin
            d_req     = 1'b1;
            d_wb      = 1'($urandom);
            d_addr    = AW'($urandom);
            d_wb_addr = AW'($urandom);
            d_wb_line = {$urandom, $urandom};
        end
        rst_n = ($urandom_range(0, 399) != 0);
    endtask

    task automatic cycle();
        p_rst_n     = rst_n;
        p_i_req     = i_req;
        p_d_req     = d_req;
        p_d_wb      = d_wb;
        p_i_addr    = i_addr;
        p_d_addr    = d_addr;
        p_d_wb_addr = d_wb_addr;
        p_d_wb_line = d_wb_line;
        p_mem_valid = mem_valid;
        p_mem_rdata = mem_rdata;
        @(posedge clk);
        #1;
        model_update();
        model_check();
        mem_respond();
        if (auto_req) drive_random();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int            rdy_at;
        int            npulse;
        int            nd;
        int            ni;
        bit            seen;
        logic [LW-1:0] saved;
        logic [LW-1:0] wb_data;
        logic [AW:0]   acc_log[$];
        bit            rdy_log[$];

        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wb = 1'b0;
        d_addr = '0; d_wb_addr = '0; d_wb_line = '0; mem_valid = 1'b0; mem_rdata = '0;

        // Reset values.
        do_reset(3);
        check_eq("reset_i_line", i_line, 64'(0));
        check_eq("reset_d_line", d_line, 64'(0));
        check_eq("reset_mem_en", 64'(mem_en), 64'(0));

        // Single I fill with a 4-cycle memory.
        fixed_lat   = 4;
        force_en    = 1'b1;
        force_rdata = 64'hA5A5_0000_FFFF_0001;
        i_addr = 16'h1234; i_req = 1'b1;
        rdy_at = -1; npulse = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (k == 1) begin
                check_eq("t1_addr", 64'(mem_addr), 64'h1230);
                check_eq("t1_we", 64'(mem_we), 64'(0));
            end
            if (i_rdy) begin
                npulse++;
                if (rdy_at < 0) rdy_at = k;
                check_eq("t1_line", i_line, 64'hA5A5_0000_FFFF_0001);
                i_req = 1'b0;
            end
        end
        check_eq("t1_latency", 64'(rdy_at), 64'(6));
        check_eq("t1_pulses", 64'(npulse), 64'(1));
        force_en = 1'b0;

        // D miss with dirty victim.
        fixed_lat = 3;
        wb_data = 64'h1122_3344_5566_7788;
        d_req = 1'b1; d_wb = 1'b1; d_wb_addr = 16'h0040; d_addr = 16'h0080; d_wb_line = wb_data;
        nd = 0; ni = 0;
        for (int k = 0; k < 25; k++) begin
            cycle();
            if (mem_en && mem_valid) acc_log.push_back({mem_we, mem_addr});
            if (i_rdy) ni++;
            if (d_rdy) begin
                nd++;
                d_req = 1'b0; d_wb = 1'b0;
            end
        end
        check_eq("t2_nacc", 64'(acc_log.size()), 64'(2));
        check_eq("t2_acc0", 64'((acc_log.size() > 0) ? acc_log[0] : '1), 64'({1'b1, 16'h0040}));
        check_eq("t2_acc1", 64'((acc_log.size() > 1) ? acc_log[1] : '1), 64'({1'b0, 16'h0080}));
        check_eq("t2_d_rdy", 64'(nd), 64'(1));
        check_eq("t2_i_rdy", 64'(ni), 64'(0));
        check_eq("t2_wb_mem", mem_arr.exists(16'h0040) ? mem_arr[16'h0040] : '0, wb_data);
        check_eq("t2_d_line", d_line, mem_read(16'h0080));

        // Both sides held after reset: D, I, D, I.
        do_reset(2);
        fixed_lat = 2;
        i_addr = 16'h0100; d_addr = 16'h0208; d_wb = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 100 && rdy_log.size() < 4; k++) begin
            cycle();
            if (i_rdy || d_rdy) rdy_log.push_back(d_rdy);
        end
        i_req = 1'b0; d_req = 1'b0;
        check_eq("t3_count", 64'(rdy_log.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t3_order%0d", k), 64'((k < rdy_log.size()) ? rdy_log[k] : 1'bx),
                     64'((k % 2) == 0));
        end
        for (int k = 0; k < 4; k++) cycle();

        // Reset during writeback aborts, then a fresh I request is served.
        fixed_lat = 4;
        d_req = 1'b1; d_wb = 1'b1; d_wb_addr = 16'h0300; d_addr = 16'h0400; d_wb_line = 64'h0F0F;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cycle();
            seen = mem_en && mem_we;
        end
        check_eq("t4_wb_seen", 64'(seen), 64'(1));
        cycle();
        rst_n = 1'b0; d_req = 1'b0; d_wb = 1'b0;
        cycle();
        check_eq("t4_mem_en", 64'(mem_en), 64'(0));
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (d_rdy) nd++;
        end
        check_eq("t4_no_d_rdy", 64'(nd), 64'(0));
        i_req = 1'b1; i_addr = 16'h0200; ni = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (i_rdy) begin
                ni++;
                i_req = 1'b0;
            end
        end
        check_eq("t4_i_rdy", 64'(ni), 64'(1));

        // Request dropped after grant, stray mem_valid while not accessing.
        fixed_lat = 3;
        i_req = 1'b1; i_addr = 16'h0348;
        cycle();
        i_req = 1'b0;
        ni = 0; saved = '0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (i_rdy) begin
                ni++;
                saved = i_line;
            end
            if (!mem_en) begin
                mem_valid = 1'b1;
                mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            end
        end
        check_eq("t5_i_rdy", 64'(ni), 64'(1));
        check_eq("t5_line_kept", i_line, saved);
        check_eq("t5_line_val", saved, mem_read(16'h0348));
        mem_valid = 1'b0;
        cycle();

        // Randomized traffic with variable latency, stray pulses and resets.
        fixed_lat   = -1;
        spurious_en = 1'b1;
        auto_req    = 1'b1;
        for (int k = 0; k < 3000; k++) cycle();
        auto_req    = 1'b0;
        spurious_en = 1'b0;
        rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 40; k++) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mem_arbiter
